// File: rtl/srec_mem_arbiter.sv
// Arbitrates one memory port between an S-record loader byte stream (FIFO-buffered) and a CPU.
// Optional macro SREC_ARB_FAIRNESS_EN forces a CPU grant after 4 back-to-back loader grants.
module srec_mem_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ld_address,
    input  logic [7:0]  ld_byte,
    input  logic        ld_write,
    input  logic        ld_error,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        overflow,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, LD_XFER, CPU_XFER} state_t;
    state_t state, state_nx;

    logic [31:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]  fifo_data [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full, push_req, push, pop, drop, done;
    logic        grant_ld, grant_cpu, fair_force;
    logic [31:0] head_addr;
    logic [7:0]  head_data;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_addr  = fifo_addr[rd_ptr[AW-1:0]];
    assign head_data  = fifo_data[rd_ptr[AW-1:0]];
    assign done       = mem_req && mem_ready;
    assign pop        = done && (state == LD_XFER);
    assign push_req   = ld_write && !ld_error;
    assign push       = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign busy       = !fifo_empty || (state != IDLE);

`ifdef SREC_ARB_FAIRNESS_EN
    logic [2:0] fair_cnt;
    assign fair_force = cpu_req && (fair_cnt == 3'd4);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  fair_cnt <= '0;
        else if (!cpu_req || grant_cpu) fair_cnt <= '0;
        else if (grant_ld && fair_cnt != 3'd4) fair_cnt <= fair_cnt + 3'd1;
    end
`else
    assign fair_force = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Loader entries being flushed are never granted, even in the flush cycle.
    always_comb begin
        state_nx  = state;
        grant_ld  = 1'b0;
        grant_cpu = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !ld_error && !fair_force) begin
                    grant_ld = 1'b1;
                    state_nx = LD_XFER;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_nx  = CPU_XFER;
                end
            end
            LD_XFER, CPU_XFER: if (mem_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= ld_address;
            fifo_data[wr_ptr[AW-1:0]] <= ld_byte;
        end
    end

    // A flush keeps the head only while it is the entry in flight, so its pop stays balanced.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (ld_error)  wr_ptr <= (state == LD_XFER) ? rd_ptr + PTR_ONE : rd_ptr;
            else if (push) wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            overflow    <= 1'b0;
        end else begin
            cpu_ack  <= done && (state == CPU_XFER);
            overflow <= overflow | drop;
            if (done && state == CPU_XFER) cpu_rdata <= mem_rdata;
            if (grant_ld) begin
                mem_req     <= 1'b1;
                mem_we      <= 1'b1;
                mem_address <= {head_addr[31:2], 2'b00};
                mem_wdata   <= {4{head_data}};
                mem_be      <= 4'b0001 << head_addr[1:0];
            end else if (grant_cpu) begin
                mem_req     <= 1'b1;
                mem_we      <= cpu_we;
                mem_address <= cpu_address;
                mem_wdata   <= cpu_wdata;
                mem_be      <= cpu_be;
            end else if (done) begin
                mem_req     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_srec_mem_arbiter.sv
// Self-checking bench for srec_mem_arbiter: vector table for loader writes, scoreboard of
// expected memory transactions checked at each completion, hand sequences for corner cases.
module tb_srec_mem_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ld_address;
    logic [7:0]  ld_byte;
    logic        ld_write, ld_error;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_address, cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_address, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        overflow, busy;

    srec_mem_arbiter #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .ld_address(ld_address), .ld_byte(ld_byte), .ld_write(ld_write), .ld_error(ld_error),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    typedef struct {
        logic [31:0] ld_addr;
        logic [7:0]  ld_byte;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    txn_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.be = be;
        exp_q.push_back(t);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            tick();
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: a transaction completes at the posedge following a negedge with req & ready.
    always @(negedge clock) begin
        if (reset_n && mem_req && mem_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_txn: got addr %h wdata %h be %b, expected none",
                         mem_address, mem_wdata, mem_be);
            end else begin
                txn_t e;
                e = exp_q.pop_front();
                chk("txn_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("txn_addr", mem_address, e.addr);
                chk("txn_wdata", mem_wdata, e.wdata);
                chk("txn_be", {28'd0, mem_be}, {28'd0, e.be});
            end
        end
    end

    vec_t vt[4];
    logic [31:0] fair_addr [6];
    logic [31:0] fair_wdata[6];
    logic [3:0]  fair_be   [6];
    int acks;

    initial begin
        vt[0] = '{32'h0000_0000, 8'h11, 32'h0000_0000, 32'h1111_1111, 4'b0001};
        vt[1] = '{32'h0000_1003, 8'h3C, 32'h0000_1000, 32'h3C3C_3C3C, 4'b1000};
        vt[2] = '{32'hFFFF_FFFD, 8'h80, 32'hFFFF_FFFC, 32'h8080_8080, 4'b0010};
        vt[3] = '{32'h1234_5676, 8'hFF, 32'h1234_5674, 32'hFFFF_FFFF, 4'b0100};
        fair_addr  = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h204, 32'h204};
        fair_wdata = '{32'h3030_3030, 32'h3131_3131, 32'h3232_3232, 32'h3333_3333,
                       32'h3434_3434, 32'h3535_3535};
        fair_be    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        reset_n = 1'b0; ld_address = '0; ld_byte = '0; ld_write = 1'b0; ld_error = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0; cpu_be = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single loader write and its latency.
        mem_ready = 1'b1;
        ld_address = 32'h0000_0102; ld_byte = 8'hA5; ld_write = 1'b1;
        expect_txn(1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'b0100);
        tick();
        ld_write = 1'b0;
        chk("lat_req_edge_n", {31'd0, mem_req}, 32'd0);
        chk("lat_busy_edge_n", {31'd0, busy}, 32'd1);
        tick();
        chk("lat_req_edge_n1", {31'd0, mem_req}, 32'd1);
        tick();
        chk("lat_req_done", {31'd0, mem_req}, 32'd0);
        wait_idle("single_idle", 10);

        // Table of loader writes covering every byte lane.
        for (int i = 0; i < 4; i++) begin
            ld_address = vt[i].ld_addr; ld_byte = vt[i].ld_byte; ld_write = 1'b1;
            expect_txn(1'b1, vt[i].exp_addr, vt[i].exp_wdata, vt[i].exp_be);
            tick();
            ld_write = 1'b0;
            wait_idle("vec_idle", 10);
        end

        // Overflow: five pushes into a depth-4 FIFO with memory stalled.
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_address = 32'h300 + 32'(i); ld_byte = 8'h50 + 8'(i); ld_write = 1'b1;
            tick();
        end
        ld_write = 1'b0;
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        expect_txn(1'b1, 32'h300, 32'h5050_5050, 4'b0001);
        expect_txn(1'b1, 32'h300, 32'h5151_5151, 4'b0010);
        expect_txn(1'b1, 32'h300, 32'h5252_5252, 4'b0100);
        expect_txn(1'b1, 32'h300, 32'h5353_5353, 4'b1000);
        mem_ready = 1'b1;
        wait_idle("ovf_idle", 30);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // CPU read with a 3-cycle memory stall.
        mem_ready = 1'b0;
        cpu_we = 1'b0; cpu_address = 32'h10; cpu_wdata = 32'h0; cpu_be = 4'b1111; cpu_req = 1'b1;
        expect_txn(1'b0, 32'h10, 32'h0, 4'b1111);
        tick();
        chk("cpu_grant", {31'd0, mem_req}, 32'd1);
        tick(); tick(); tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            mem_rdata = 32'h0;
            if (cpu_ack) begin
                acks++;
                chk("cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
                cpu_req = 1'b0;
            end
        end
        chk("cpu_ack_count", 32'(acks), 32'd1);
        chk("cpu_rdata_held", cpu_rdata, 32'hDEAD_BEEF);

        // Loader vs held CPU request: six queued bytes.
        cpu_we = 1'b1; cpu_address = 32'h40; cpu_wdata = 32'hCAFE_F00D; cpu_be = 4'b1111;
        mem_rdata = 32'h1357_9BDF;
`ifdef SREC_ARB_FAIRNESS_EN
        for (int i = 0; i < 4; i++) expect_txn(1'b1, fair_addr[i], fair_wdata[i], fair_be[i]);
        expect_txn(1'b1, 32'h40, 32'hCAFE_F00D, 4'b1111);
        for (int i = 4; i < 6; i++) expect_txn(1'b1, fair_addr[i], fair_wdata[i], fair_be[i]);
`else
        for (int i = 0; i < 6; i++) expect_txn(1'b1, fair_addr[i], fair_wdata[i], fair_be[i]);
        expect_txn(1'b1, 32'h40, 32'hCAFE_F00D, 4'b1111);
`endif
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            ld_write = (i < 6);
            ld_address = 32'h200 + 32'(i);
            ld_byte = 8'h30 + 8'(i);
            if (i == 1) cpu_req = 1'b1;
            tick();
            if (cpu_ack) begin
                acks++;
                cpu_req = 1'b0;
            end
        end
        ld_write = 1'b0;
        chk("fair_ack_count", 32'(acks), 32'd1);
        chk("fair_q_drained", 32'(exp_q.size()), 32'd0);
        chk("fair_rdata", cpu_rdata, 32'h1357_9BDF);

        // ld_error during first of three loader transactions.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_address = 32'h400 + 32'(i); ld_byte = 8'h60 + 8'(i); ld_write = 1'b1;
            tick();
        end
        ld_write = 1'b0;
        expect_txn(1'b1, 32'h400, 32'h6060_6060, 4'b0001);
        ld_error = 1'b1;
        tick();
        ld_error = 1'b0;
        chk("err_active_kept", {31'd0, mem_req}, 32'd1);
        mem_ready = 1'b1;
        wait_idle("err_idle", 10);
        for (int i = 0; i < 5; i++) tick();
        chk("err_busy_after", {31'd0, busy}, 32'd0);

        // Reset in the middle of a loader transaction.
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_address = 32'h500 + 32'(4 * i); ld_byte = 8'h70 + 8'(i); ld_write = 1'b1;
            tick();
        end
        ld_write = 1'b0;
        chk("rst_mid_active", {31'd0, mem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_mid_rdata", cpu_rdata, 32'd0);
        tick();
        reset_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_mid_no_write", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_idle", {31'd0, busy}, 32'd0);
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
